spi_flash_target: RTL
=====================

Name: spi_flash_target

Overview:
- Synthesizable SPI flash responder (mode 0, MSB first). It is the target-side counterpart of the flash master in the FPGA top.
- Used as an on-board flash emulator: a second board, or a loopback header, runs the boot/flash-read path against a BRAM image instead of the real config flash.
- Samples the asynchronous SPI pins in the system clock domain. Answers READ (0x03), JEDEC ID (0x9F) and RELEASE POWER-DOWN (0xAB) from a fixed-latency memory read port.

Parameters:
- ADDR_W, 24, byte-address width presented on mem_addr; only the low ADDR_W bits of the 24-bit SPI address are used.
- MEM_LAT, 1, clk cycles from mem_req to mem_rdata valid; fixed, no stall.
- JEDEC_ID, 24'hEF4016, three bytes returned for 0x9F, MSB byte first.

Ports:
- clk  in  1  system clock; must be at least 8x f_sclk.
- rst  in  1  synchronous, active-high reset.
- f_sclk  in  1  SPI clock, asynchronous.
- f_cs  in  1  SPI chip select, active low, asynchronous.
- f_mosi  in  1  SPI data from master, asynchronous.
- f_miso  out  1  SPI data to master.
- f_miso_oe  out  1  output enable for the f_miso pad; high only while selected and shifting a response.
- mem_req  out  1  single-cycle read strobe.
- mem_addr  out  ADDR_W  byte address, valid while mem_req is high.
- mem_rdata  in  8  read data, valid exactly MEM_LAT cycles after mem_req.
- busy  out  1  high while f_cs is (synchronized) low.

Behaviour:
- Synchronization: f_sclk, f_cs and f_mosi each pass through 2-FF synchronizers plus one history FF.
  - rise = sync & ~hist; fall = ~sync & hist, both evaluated on the synchronized f_sclk.
  - f_mosi is captured on rise.
  - f_miso updates on the cycle after fall.
- Reset values: f_miso=1, f_miso_oe=0, mem_req=0, mem_addr=0, busy=0, state=IDLE, bit counter=0.
- Any cycle with synchronized f_cs high:
  - state goes to IDLE and the shift register clears.
  - f_miso_oe=0, busy=0.
  - This overrides every other event, including a coincident rise or fall.
- States:
  - IDLE: on f_cs falling go to CMD, bit counter=0.
  - CMD: shift 8 bits on rise. On the 8th bit: 0x03 to ADDR; 0x9F to ID; 0xAB to ID (see below); anything else to IGNORE.
  - ADDR: shift 24 bits. On the 24th bit, issue mem_req with mem_addr = addr[ADDR_W-1:0], then go to READ.
  - READ:
    - Load tx byte from mem_rdata when it is valid.
    - Shift it out MSB first on successive falls.
    - On the fall that shifts out the last bit, issue mem_req for addr+1 (wraps modulo 2^ADDR_W) so the next byte is loaded before its first fall.
    - Continues until f_cs rises.
  - ID:
    - 0x9F returns JEDEC_ID bytes 2,1,0, then 0xFF indefinitely.
    - 0xAB first ignores 3 dummy bytes, then returns byte0 of JEDEC_ID repeatedly.
  - IGNORE: f_miso_oe=0; wait for f_cs high.
- f_miso_oe is asserted from the first fall after command (or address) completion until deselect.
- Timing requirement: the first response bit is driven 3+MEM_LAT+1 clk after the final rise. With clk >= 8x f_sclk this lands before the master's next rising edge. Violating the ratio is not detected.
- Partial byte at deselect: discarded, no memory request issued.
- rst asserted mid-transaction: immediate return to reset values. The transaction resumes only after f_cs goes high and then falls again.

Optional Feature:
- Macro: SPI_FLASH_TARGET_FAST_READ_EN.
- Defined: command 0x0B is accepted. It is ADDR (24 bits), then 8 dummy bits shifted in and ignored, then READ. mem_req is issued at the end of the dummy byte.
- Undefined: 0x0B goes to IGNORE.

Decomposition:
- Package spi_flash_pkg holds:
  - Opcode constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_RDID=8'h9F, CMD_RES=8'hAB.
  - The state enum typedef (IDLE, CMD, ADDR, DUMMY, READ, ID, IGNORE).
- One sub-module, spi_pin_sync: synchronizers plus rise/fall/cs-edge detection, 3 inputs to synchronized levels and strobes. It is reused by any future SPI target.

Test Plan:
- Reset: hold rst 4 cycles with f_cs low and toggling f_sclk -> f_miso_oe=0, f_miso=1, no mem_req, busy=0.
- READ at 0x000010, memory byte = addr[7:0] ^ 8'hA5, 4 bytes clocked -> mem_addr sequence 0x10..0x13, MISO bytes B5,B4,B7,B6, one mem_req per byte.
- JEDEC: 0x9F then 32 clocks -> EF,40,16,FF; 0xAB + 3 dummy bytes -> 16,16.
- Wrap: ADDR_W=8, READ at 0xFF, 2 bytes -> mem_addr 0xFF then 0x00.
- Abort: deselect after 5 address bits, then new READ at 0x000020 -> no stray mem_req; first mem_addr=0x20. Unknown opcode 0x55 -> f_miso_oe stays 0.
- FAST_READ_EN defined: 0x0B, addr 0x000004, dummy 0xFF -> first byte from 0x04 appears after the dummy byte. Undefined: f_miso_oe stays 0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared definitions for the SPI flash target.
//   - Opcode constants for the commands the target answers.
//   - state_t: protocol state of the target (exported on dbg_state).
//   - id_byte(): byte returned at a given position of an ID response.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDID      = 8'h9F;
  localparam logic [7:0] CMD_RES       = 8'hAB;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    READ,
    ID,
    IGNORE
  } state_t;

  // RDID returns the three ID bytes MSB first and then 0xFF forever.
  // RES answers three dummy byte slots with 0xFF, then repeats the low ID byte.
  // idx saturates at 3, which is the steady-state byte for both commands.
  function automatic logic [7:0] id_byte(input logic [23:0] id,
                                         input logic        res,
                                         input logic [1:0]  idx);
    logic [7:0] b;
    b = 8'hFF;
    if (res) begin
      if (idx == 2'd3) b = id[7:0];
    end else begin
      case (idx)
        2'd0:    b = id[23:16];
        2'd1:    b = id[15:8];
        2'd2:    b = id[7:0];
        default: b = 8'hFF;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: brings asynchronous SPI target pins into the clk domain.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sclk, cs, mosi      raw SPI pins (cs active low)
//   sclk_rise/fall      one-cycle strobes on synchronized sclk edges
//   cs_level            synchronized cs level (1 = deselected)
//   cs_fall             one-cycle strobe when the target becomes selected
//   mosi_level          synchronized mosi, aligned with the sclk strobes
// The cs chain resets to "selected" so that a master already holding cs low
// across reset produces no fall; a new transaction needs a real high->low.
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_level,
  output logic cs_fall,
  output logic mosi_level
);

  logic [1:0] sclk_s;
  logic [1:0] cs_s;
  logic [1:0] mosi_s;
  logic       sclk_h;
  logic       cs_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= 2'b00;
      cs_s   <= 2'b00;
      mosi_s <= 2'b00;
      sclk_h <= 1'b0;
      cs_h   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      cs_s   <= {cs_s[0], cs};
      mosi_s <= {mosi_s[0], mosi};
      sclk_h <= sclk_s[1];
      cs_h   <= cs_s[1];
    end
  end

  assign sclk_rise  = sclk_s[1] & ~sclk_h;
  assign sclk_fall  = ~sclk_s[1] & sclk_h;
  assign cs_level   = cs_s[1];
  assign cs_fall    = ~cs_s[1] & cs_h;
  assign mosi_level = mosi_s[1];

endmodule

// File: rtl/spi_flash_target.sv
// spi_flash_target: SPI mode-0 flash responder backed by a memory read port.
// Answers READ (0x03), RDID (0x9F) and RES (0xAB); FAST_READ (0x0B) is
// accepted only when SPI_FLASH_TARGET_FAST_READ_EN is defined.
// Ports:
//   clk, rst             system clock (>= 8x f_sclk), sync active-high reset
//   f_sclk, f_cs, f_mosi asynchronous SPI pins from the master (f_cs active low)
//   f_miso, f_miso_oe    response bit and its pad enable
//   mem_req, mem_addr    read strobe and byte address
//   mem_rdata            read data, valid exactly MEM_LAT cycles after mem_req
//   busy                 synchronized f_cs is low
//   dbg_state            current protocol state
// Memory handshake: mem_req is a single-cycle strobe with mem_addr valid in
// the same cycle; there is no ready, and mem_rdata is taken exactly MEM_LAT
// cycles later without any stall.
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter int          MEM_LAT  = 1,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_sclk,
  input  logic              f_cs,
  input  logic              f_mosi,
  output logic              f_miso,
  output logic              f_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output state_t            dbg_state
);

  logic sclk_rise, sclk_fall, cs_hi, cs_fall, mosi_s;

  spi_pin_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .sclk       (f_sclk),
    .cs         (f_cs),
    .mosi       (f_mosi),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall),
    .cs_level   (cs_hi),
    .cs_fall    (cs_fall),
    .mosi_level (mosi_s)
  );

  state_t             state_q, state_d;
  logic [22:0]        sr;        // incoming bits; 23 kept, the 24th is mosi_s
  logic [4:0]         bit_cnt;   // rises seen in the current state
  logic [7:0]         tx_sr;     // outgoing byte, MSB leaves first
  logic [2:0]         tx_cnt;    // bits shifted out of tx_sr
  logic [1:0]         id_cnt;    // ID response byte position, saturates at 3
  logic [1:0]         id_nxt;
  logic               is_res;
  logic [MEM_LAT-1:0] rv_pipe;   // mem_req delayed to the data-valid cycle
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
  logic               is_fast;
`endif

  logic [7:0]  cmd_byte;
  logic [23:0] addr_word;
  logic        cmd_done, addr_done, dummy_done, last_bit_fall;

  assign cmd_byte      = {sr[6:0], mosi_s};
  assign addr_word     = {sr, mosi_s};
  assign cmd_done      = (state_q == CMD)   && sclk_rise && (bit_cnt == 5'd7);
  assign addr_done     = (state_q == ADDR)  && sclk_rise && (bit_cnt == 5'd23);
  assign dummy_done    = (state_q == DUMMY) && sclk_rise && (bit_cnt == 5'd7);
  assign last_bit_fall = sclk_fall && (tx_cnt == 3'd7);
  assign id_nxt        = (id_cnt == 2'd3) ? 2'd3 : id_cnt + 2'd1;
  assign dbg_state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_hi) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = CMD;
        CMD: if (cmd_done) begin
          case (cmd_byte)
            CMD_READ:          state_d = ADDR;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
            CMD_FAST_READ:     state_d = ADDR;
`endif
            CMD_RDID, CMD_RES: state_d = ID;
            default:           state_d = IGNORE;
          endcase
        end
        ADDR: if (addr_done) begin
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
          state_d = is_fast ? DUMMY : READ;
`else
          state_d = READ;
`endif
        end
        DUMMY: if (dummy_done) state_d = READ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_miso    <= 1'b1;
      f_miso_oe <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      bit_cnt   <= 5'd0;
      sr        <= '0;
      tx_sr     <= 8'h00;
      tx_cnt    <= 3'd0;
      id_cnt    <= 2'd0;
      is_res    <= 1'b0;
      rv_pipe   <= '0;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
      is_fast   <= 1'b0;
`endif
    end else begin
      mem_req <= 1'b0;
      rv_pipe <= (rv_pipe << 1) | MEM_LAT'(mem_req);
      busy    <= ~cs_hi;

      if (state_d != state_q) bit_cnt <= 5'd0;
      else if (sclk_rise)     bit_cnt <= bit_cnt + 5'd1;

      if (cs_hi) begin
        // Deselect wins over any coincident sclk edge; a partial byte is dropped.
        sr        <= '0;
        tx_cnt    <= 3'd0;
        f_miso    <= 1'b1;
        f_miso_oe <= 1'b0;
      end else begin
        if (sclk_rise) sr <= {sr[21:0], mosi_s};

        if (cmd_done) begin
          is_res <= (cmd_byte == CMD_RES);
          id_cnt <= 2'd0;
          tx_cnt <= 3'd0;
          tx_sr  <= id_byte(JEDEC_ID, cmd_byte == CMD_RES, 2'd0);
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
          is_fast <= (cmd_byte == CMD_FAST_READ);
`endif
        end

        if (addr_done) begin
          mem_addr <= addr_word[ADDR_W-1:0];
          tx_cnt   <= 3'd0;
`ifdef SPI_FLASH_TARGET_FAST_READ_EN
          if (!is_fast) mem_req <= 1'b1;
`else
          mem_req <= 1'b1;
`endif
        end

        if (dummy_done) mem_req <= 1'b1;

        // With clk >= 8x f_sclk a memory load never coincides with a fall.
        if (rv_pipe[MEM_LAT-1] && state_q == READ) begin
          tx_sr <= mem_rdata;
        end else if (sclk_fall && (state_q == READ || state_q == ID)) begin
          f_miso    <= tx_sr[7];
          f_miso_oe <= 1'b1;
          tx_cnt    <= tx_cnt + 3'd1;
          if (state_q == ID && last_bit_fall) begin
            tx_sr  <= id_byte(JEDEC_ID, is_res, id_nxt);
            id_cnt <= id_nxt;
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
          // Prefetch the next byte while the last bit of this one is on the wire.
          if (state_q == READ && last_bit_fall) begin
            mem_req  <= 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
      end
    end
  end

endmodule
